// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, default boot PC and the
// instruction width that the decoder also relies on.
package ysyx_22050550_ifu_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

   typedef enum logic [1:0] {
      ST_REQ   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_HOLD  = 2'b11
   } ifu_state_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_22050550_Reg.sv
// Generic enable register with synchronous active-high reset to a fixed value.
module ysyx_22050550_Reg #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_o <= RST_VAL;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem read in flight and
// hands {pc, instr, fault} to decode over a valid/ready handshake.
module ysyx_22050550_ifu
   import ysyx_22050550_ifu_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               imem_rsp_err,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               out_fault,
   output logic [1:0]         dbg_state_o
);

   // Handshakes: a transfer happens on a cycle where valid & ready are both high
   // at the rising edge; valid never depends on ready, and the payload is held
   // stable while valid is high and ready is low.

   ifu_state_e         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               pc_en;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               fault_q, fault_d;
   logic               cap_en;
   logic               misaligned;
   logic               consume;
   logic               capture_rsp;
   logic               capture_fault;

   assign misaligned = is_misaligned(pc_q[1:0]);

   // Redirect masks every other event, so each qualifier carries ~redirect_valid.
   assign consume       = (state_q == ST_HOLD) & out_ready & ~redirect_valid;
   assign capture_rsp   = (state_q == ST_WAIT) & imem_rsp_valid & ~redirect_valid;
   assign capture_fault = (state_q == ST_REQ) & misaligned & ~redirect_valid;

   always_comb begin
      pc_en   = redirect_valid | consume;
      pc_d    = redirect_valid ? redirect_pc : pc_q + PC_W'(4);
      cap_en  = capture_rsp | capture_fault;
      instr_d = (capture_rsp & ~imem_rsp_err) ? imem_rsp_data : '0;
      fault_d = capture_rsp ? imem_rsp_err : 1'b1;
   end

   ysyx_22050550_Reg #(.W(PC_W), .RST_VAL(RESET_PC)) u_pc_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (pc_en),
      .d_i  (pc_d),
      .q_o  (pc_q)
   );

   ysyx_22050550_Reg #(.W(INSTR_W), .RST_VAL('0)) u_instr_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (cap_en),
      .d_i  (instr_d),
      .q_o  (instr_q)
   );

   ysyx_22050550_Reg #(.W(1), .RST_VAL(1'b0)) u_fault_reg (
      .clk  (clk),
      .rst  (rst),
      .en_i (cap_en),
      .d_i  (fault_d),
      .q_o  (fault_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_REQ;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_REQ: begin
            if (redirect_valid)                 state_d = ST_REQ;
            else if (misaligned)                state_d = ST_HOLD;
            else if (imem_req_ready)            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid)                 state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
            else if (imem_rsp_valid)            state_d = ST_HOLD;
         end
         // A response arriving alongside a redirect still retires the stale read,
         // otherwise DRAIN would wait for a response that never comes.
         ST_DRAIN: begin
            if (imem_rsp_valid)                 state_d = ST_REQ;
         end
         ST_HOLD: begin
            if (redirect_valid | out_ready)     state_d = ST_REQ;
         end
         default:                               state_d = ST_REQ;
      endcase
   end

   always_comb begin
      imem_req_valid = (state_q == ST_REQ) & ~redirect_valid & ~misaligned;
      imem_req_addr  = pc_q;
      out_valid      = (state_q == ST_HOLD) & ~redirect_valid;
      out_pc         = pc_q;
      out_instr      = instr_q;
      out_fault      = fault_q;
      dbg_state_o    = state_q;
   end

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Directed bench for the fetch unit: a memory responder, a transaction-level PC
// model checked every cycle, and hand-computed expectations for each scenario.
module tb_ysyx_22050550_ifu;
   import ysyx_22050550_ifu_pkg::*;

   localparam int PC_W = 64;

   logic              clk;
   logic              rst;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [PC_W-1:0]   imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              imem_rsp_err;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [31:0]       out_instr;
   logic              out_fault;
   logic [1:0]        dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   int              rsp_lat  = 1;
   logic [PC_W-1:0] err_addr = '1;
   int              fire_count = 0;
   logic [PC_W-1:0] exp_q[$];

   ysyx_22050550_ifu #(.PC_W(PC_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault),
      .dbg_state_o    (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] data_of(input logic [PC_W-1:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   task automatic chk(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: answers each accepted read rsp_lat cycles later.
   initial begin
      logic            pend;
      int              pend_cnt;
      logic [PC_W-1:0] pend_addr;
      pend = 1'b0;
      pend_cnt = 0;
      pend_addr = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_cnt  = rsp_lat;
            fire_count++;
         end
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         imem_rsp_err   = 1'b0;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend           = 1'b0;
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = data_of(pend_addr);
               imem_rsp_err   = (pend_addr == err_addr);
            end
         end
      end
   end

   // Compare process: architectural PC model driven by redirects and consumed
   // instructions; every meaningful output is checked against it each cycle.
   initial begin
      logic [PC_W-1:0] model_pc;
      logic            outst;
      logic            exp_fault;
      logic [31:0]     exp_instr;
      model_pc = DEFAULT_RESET_PC;
      outst    = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            model_pc = DEFAULT_RESET_PC;
            outst    = 1'b0;
         end else begin
            if (imem_req_valid) begin
               chk("req_addr_model", imem_req_addr, model_pc);
               chk("req_aligned", {62'd0, imem_req_addr[1:0]}, '0);
               chk("one_outstanding", {63'd0, outst}, '0);
            end
            if (out_valid) begin
               exp_fault = (model_pc[1:0] != 2'b00) || (model_pc == err_addr);
               exp_instr = exp_fault ? 32'h0 : data_of(model_pc);
               chk("out_pc_model", out_pc, model_pc);
               chk("out_fault_model", {63'd0, out_fault}, {63'd0, exp_fault});
               chk("out_instr_model", {32'd0, out_instr}, {32'd0, exp_instr});
            end
            if (imem_rsp_valid) outst = 1'b0;
            if (imem_req_valid && imem_req_ready) outst = 1'b1;
            if (redirect_valid) model_pc = redirect_pc;
            else if (out_valid && out_ready) model_pc = model_pc + 64'd4;
         end
      end
   end

   task automatic wait_fire(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) ok = 1'b1;
         else tick();
      end
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: no request accepted within 30 cycles", name);
   endtask

   task automatic wait_out(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
         else tick();
      end
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: out_valid not seen within 30 cycles", name);
   endtask

   task automatic redirect(input logic [PC_W-1:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   // Main directed sequence
   initial begin
      int cyc_prev;
      int cyc_now;
      int nfire0;
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // reset release: first fetch at the boot PC
      @(negedge clk);
      chk("reset_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("reset_req_addr", imem_req_addr, 64'h8000_0000);
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_state", {62'd0, dbg_state}, {62'd0, ST_REQ});

      // streaming: one request every 3 cycles at +4 steps
      exp_q.push_back(64'h8000_0004);
      exp_q.push_back(64'h8000_0008);
      cyc_prev = 0;
      cyc_now  = 0;
      while (exp_q.size() != 0) begin
         tick();
         wait_fire("stream_fire");
         cyc_now = cyc_now + 1;
         chk("stream_addr", imem_req_addr, exp_q.pop_front());
      end
      tick();

      // stall at 0x80000004: payload held, no new request
      out_ready = 1'b0;
      redirect(64'h8000_0004);
      wait_out("stall_out");
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         chk("stall_pc", out_pc, 64'h8000_0004);
         chk("stall_instr", {32'd0, out_instr}, 64'h0004_0013);
         chk("stall_noreq", {63'd0, imem_req_valid}, 64'd0);
      end
      tick();
      out_ready = 1'b1;

      // redirect while WAIT, stale response two cycles later
      rsp_lat = 3;
      tick();
      wait_fire("drain_fire0");
      tick();
      redirect(64'h8000_1000);
      rsp_lat = 1;
      nfire0 = fire_count;
      wait_fire("drain_fire1");
      chk("drain_next_addr", imem_req_addr, 64'h8000_1000);
      chk("drain_fire_count", 64'(fire_count), 64'(nfire0));

      // redirect coincident with the response
      tick();
      wait_fire("coinc_fire");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2000;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("coinc_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("coinc_req_addr", imem_req_addr, 64'h8000_2000);

      // bus error
      tick();
      err_addr = 64'h8000_0010;
      redirect(64'h8000_0010);
      wait_out("err_out");
      chk("err_pc", out_pc, 64'h8000_0010);
      chk("err_fault", {63'd0, out_fault}, 64'd1);
      chk("err_instr", {32'd0, out_instr}, 64'd0);

      // misaligned redirect: fault without any memory request
      tick();
      out_ready = 1'b0;
      nfire0 = fire_count;
      redirect(64'h8000_0102);
      wait_out("misal_out");
      chk("misal_pc", out_pc, 64'h8000_0102);
      chk("misal_fault", {63'd0, out_fault}, 64'd1);
      chk("misal_instr", {32'd0, out_instr}, 64'd0);
      chk("misal_no_req", 64'(fire_count), 64'(nfire0));
      tick();
      out_ready = 1'b1;
      redirect(64'h8000_0200);

      // reset while WAIT, late response must be ignored
      rsp_lat = 2;
      wait_fire("rst_fire0");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imem_req_ready = 1'b0;
      @(negedge clk);
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      tick();
      @(negedge clk);
      chk("rst_late_ignored", {63'd0, out_valid}, 64'd0);
      chk("rst_still_req", {62'd0, dbg_state}, {62'd0, ST_REQ});
      tick();
      imem_req_ready = 1'b1;
      rsp_lat = 1;
      wait_fire("rst_fire1");
      chk("rst_refetch_addr", imem_req_addr, 64'h8000_0000);
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
